// File: rtl/progmem_loader.sv
// rtl/progmem_loader.sv - UART byte stream to Avalon program-memory image loader (optional PROGMEM_LOADER_CHECKSUM_EN)
module progmem_loader #(
  parameter int          ADDR_W    = 13,
  parameter int unsigned MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    SYNC0, SYNC1, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

`ifdef PROGMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] csum;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] len;
  logic [23:0] word_buf;
  logic        fire;
  logic [15:0] len_full;
  logic        last_word;

  assign fire         = s_valid && s_ready;
  assign len_full     = {s_data, len[7:0]};
  assign last_word    = (word_cnt == len - 16'd1);
  assign m_byteenable = 4'hF;

  // Next-state decode and per-state handshake outputs
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_write   = 1'b0;
    done      = 1'b0;
    case (state)
      SYNC0: begin
        s_ready = 1'b1;
        if (fire && s_data == 8'hA5) state_nxt = SYNC1;
      end
      SYNC1: begin
        s_ready = 1'b1;
        if (fire) begin
          if (s_data == 8'h5A)      state_nxt = LEN0;
          else if (s_data != 8'hA5) state_nxt = SYNC0;
        end
      end
      LEN0: begin
        s_ready = 1'b1;
        if (fire) state_nxt = LEN1;
      end
      LEN1: begin
        s_ready = 1'b1;
        if (fire) begin
          if (len_full == 16'd0)                state_nxt = TAIL;
          else if (32'(len_full) > MAX_WORDS)   state_nxt = ERROR;
          else                                  state_nxt = DATA;
        end
      end
      DATA: begin
        s_ready = 1'b1;
        if (fire && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        m_write = 1'b1;
        if (!m_waitrequest) state_nxt = last_word ? TAIL : DATA;
      end
      CSUM: begin
        s_ready = 1'b1;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        if (fire) state_nxt = (s_data == csum) ? DONE : ERROR;
`else
        if (fire) state_nxt = ERROR;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = SYNC0;
      end
      ERROR:   state_nxt = SYNC0;
      default: state_nxt = SYNC0;
    endcase
  end

  // State register, datapath capture and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SYNC0;
      byte_cnt    <= 2'd0;
      word_cnt    <= 16'd0;
      len         <= 16'd0;
      word_buf    <= 24'd0;
      m_address   <= '0;
      m_writedata <= 32'd0;
      cpu_rst_n   <= 1'b1;
      error       <= 1'b0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt == DONE) begin
        cpu_rst_n <= 1'b1;
        error     <= 1'b0;
      end
      if (state_nxt == ERROR) error <= 1'b1;
      case (state)
        SYNC1: if (fire && s_data == 8'h5A) begin
          cpu_rst_n <= 1'b0;
          byte_cnt  <= 2'd0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum      <= 8'd0;
`endif
        end
        LEN0: if (fire) len[7:0] <= s_data;
        LEN1: if (fire) begin
          len[15:8] <= s_data;
          if (state_nxt == DATA) begin
            word_cnt  <= 16'd0;
            byte_cnt  <= 2'd0;
            m_address <= '0;
          end
        end
        DATA: if (fire) begin
          // Little-endian: earlier bytes shift toward bit 0
          word_buf <= {s_data, word_buf[23:8]};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum     <= csum + s_data;
`endif
          if (byte_cnt == 2'd3) m_writedata <= {s_data, word_buf};
        end
        WRITE: if (!m_waitrequest) begin
          m_address <= m_address + {{(ADDR_W-1){1'b0}}, 1'b1};
          word_cnt  <= word_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_loader.sv
// tb/tb_progmem_loader.sv - directed self-checking bench for progmem_loader
module tb_progmem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [12:0] m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int pass_cnt = 0;
  int total    = 0;

  int stall_n   = 0;
  int stall_cnt = 0;

  logic [31:0] wr_data_q[$];
  logic [12:0] wr_addr_q[$];
  int wr_cycles = 0;
  int done_cnt  = 0;
  int rdy_viol  = 0;

  always #5 clk = ~clk;

  progmem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_address    (m_address),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_byteenable (m_byteenable),
    .m_waitrequest(m_waitrequest),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error)
  );

  // Slave model: stall each write for stall_n cycles
  assign m_waitrequest = m_write && (stall_cnt < stall_n);
  always @(posedge clk) stall_cnt <= (m_write && m_waitrequest) ? stall_cnt + 1 : 0;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_write) wr_cycles++;
      if (m_write && !m_waitrequest) begin
        wr_data_q.push_back(m_writedata);
        wr_addr_q.push_back(m_address);
      end
      if (m_write && s_ready) rdy_viol++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_mon();
    wr_data_q.delete();
    wr_addr_q.delete();
    wr_cycles = 0;
    done_cnt  = 0;
    rdy_viol  = 0;
  endtask

  // Present a byte and hold it until the loader takes it; leaves s_valid high
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) $display("FAIL send_byte_timeout: byte %h not accepted, required acceptance", b);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    s_valid = 1'b0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt != 1) $display("FAIL done_pulse: got %0d pulses, required 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (s_ready !== 1'b1)      $display("FAIL rst_s_ready: got %b required 1", s_ready); else pass_cnt++;
    total++; if (m_write !== 1'b0)      $display("FAIL rst_m_write: got %b required 0", m_write); else pass_cnt++;
    total++; if (m_address !== 13'd0)   $display("FAIL rst_m_address: got %h required 0", m_address); else pass_cnt++;
    total++; if (m_writedata !== 32'd0) $display("FAIL rst_m_writedata: got %h required 0", m_writedata); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1)    $display("FAIL rst_cpu_rst_n: got %b required 1", cpu_rst_n); else pass_cnt++;
    total++; if (done !== 1'b0)         $display("FAIL rst_done: got %b required 0", done); else pass_cnt++;
    total++; if (error !== 1'b0)        $display("FAIL rst_error: got %b required 0", error); else pass_cnt++;
    total++; if (m_byteenable !== 4'hF) $display("FAIL rst_byteenable: got %h required f", m_byteenable); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_mon();
    stall_n = 2;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    total++; if (cpu_rst_n !== 1'b0) $display("FAIL sw_cpu_rst_low: got %b required 0", cpu_rst_n); else pass_cnt++;
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    send_byte(8'h14);
`endif
    wait_done();
    total++; if (wr_data_q.size() != 1) $display("FAIL sw_write_count: got %0d required 1", wr_data_q.size()); else pass_cnt++;
    if (wr_data_q.size() == 1) begin
      total++; if (wr_addr_q[0] !== 13'd0)        $display("FAIL sw_addr: got %h required 0", wr_addr_q[0]); else pass_cnt++;
      total++; if (wr_data_q[0] !== 32'h12345678) $display("FAIL sw_data: got %h required 12345678", wr_data_q[0]); else pass_cnt++;
    end
    total++; if (wr_cycles != 3)     $display("FAIL sw_write_hold: got %0d cycles required 3", wr_cycles); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1) $display("FAIL sw_cpu_rst_release: got %b required 1", cpu_rst_n); else pass_cnt++;
    total++; if (error !== 1'b0)     $display("FAIL sw_error: got %b required 0", error); else pass_cnt++;
  endtask

  task automatic test_junk_sync();
    clear_mon();
    stall_n = 0;
    send_byte(8'h00); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    send_byte(8'h64);
`endif
    wait_done();
    total++; if (wr_data_q.size() != 2) $display("FAIL js_write_count: got %0d required 2", wr_data_q.size()); else pass_cnt++;
    if (wr_data_q.size() == 2) begin
      total++; if (wr_addr_q[0] !== 13'd0)        $display("FAIL js_addr0: got %h required 0", wr_addr_q[0]); else pass_cnt++;
      total++; if (wr_data_q[0] !== 32'h44332211) $display("FAIL js_data0: got %h required 44332211", wr_data_q[0]); else pass_cnt++;
      total++; if (wr_addr_q[1] !== 13'd1)        $display("FAIL js_addr1: got %h required 1", wr_addr_q[1]); else pass_cnt++;
      total++; if (wr_data_q[1] !== 32'h88776655) $display("FAIL js_data1: got %h required 88776655", wr_data_q[1]); else pass_cnt++;
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_done();
    total++; if (wr_cycles != 0)     $display("FAIL zl_no_write: got %0d write cycles required 0", wr_cycles); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1) $display("FAIL zl_cpu_rst: got %b required 1", cpu_rst_n); else pass_cnt++;
  endtask

  task automatic test_len_too_big();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01); send_byte(8'h20);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (error !== 1'b1)     $display("FAIL big_error: got %b required 1", error); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b0) $display("FAIL big_cpu_rst: got %b required 0", cpu_rst_n); else pass_cnt++;
    total++; if (wr_cycles != 0)     $display("FAIL big_no_write: got %0d write cycles required 0", wr_cycles); else pass_cnt++;
    total++; if (done_cnt != 0)      $display("FAIL big_no_done: got %0d pulses required 0", done_cnt); else pass_cnt++;
    total++; if (s_ready !== 1'b1)   $display("FAIL big_resync_ready: got %b required 1", s_ready); else pass_cnt++;
  endtask

  // s_valid stays high across three heavily stalled writes; also clears the earlier error
  task automatic test_back_to_back();
    logic [7:0]  b;
    logic [7:0]  sum;
    logic [31:0] exp_w [3];
    clear_mon();
    stall_n = 5;
    sum = 8'h00;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h03); send_byte(8'h00);
    for (int k = 0; k < 12; k++) begin
      b = 8'(k * 7 + 3);
      sum = sum + b;
      exp_w[k/4][8*(k%4) +: 8] = b;
      send_byte(b);
    end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    send_byte(sum);
`endif
    wait_done();
    total++; if (wr_data_q.size() != 3) $display("FAIL b2b_write_count: got %0d required 3", wr_data_q.size()); else pass_cnt++;
    for (int w = 0; w < 3 && w < wr_data_q.size(); w++) begin
      total++; if (wr_data_q[w] !== exp_w[w]) $display("FAIL b2b_data%0d: got %h required %h", w, wr_data_q[w], exp_w[w]); else pass_cnt++;
      total++; if (wr_addr_q[w] !== 13'(w))   $display("FAIL b2b_addr%0d: got %h required %h", w, wr_addr_q[w], w); else pass_cnt++;
    end
    total++; if (rdy_viol != 0)      $display("FAIL b2b_ready_in_write: got %0d cycles required 0", rdy_viol); else pass_cnt++;
    total++; if (wr_cycles != 18)    $display("FAIL b2b_write_cycles: got %0d required 18", wr_cycles); else pass_cnt++;
    total++; if (error !== 1'b0)     $display("FAIL b2b_error_cleared: got %b required 0", error); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1) $display("FAIL b2b_cpu_rst: got %b required 1", cpu_rst_n); else pass_cnt++;
  endtask

`ifdef PROGMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    clear_mon();
    stall_n = 1;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (wr_data_q.size() != 1) $display("FAIL cs_write_count: got %0d required 1", wr_data_q.size()); else pass_cnt++;
    total++; if (error !== 1'b1)        $display("FAIL cs_error: got %b required 1", error); else pass_cnt++;
    total++; if (done_cnt != 0)         $display("FAIL cs_no_done: got %0d required 0", done_cnt); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b0)    $display("FAIL cs_cpu_rst: got %b required 0", cpu_rst_n); else pass_cnt++;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    wait_done();
    total++; if (error !== 1'b0)     $display("FAIL cs_error_cleared: got %b required 0", error); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1) $display("FAIL cs_cpu_rst_release: got %b required 1", cpu_rst_n); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_write();
    clear_mon();
    stall_n = 1000;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    s_valid = 1'b0;
    @(negedge clk);
    total++; if (m_write !== 1'b1) $display("FAIL rw_in_write: got %b required 1", m_write); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (m_write !== 1'b0)    $display("FAIL rw_m_write: got %b required 0", m_write); else pass_cnt++;
    total++; if (cpu_rst_n !== 1'b1)  $display("FAIL rw_cpu_rst: got %b required 1", cpu_rst_n); else pass_cnt++;
    total++; if (s_ready !== 1'b1)    $display("FAIL rw_sync0_ready: got %b required 1", s_ready); else pass_cnt++;
    total++; if (m_address !== 13'd0) $display("FAIL rw_m_address: got %h required 0", m_address); else pass_cnt++;
    stall_n = 0;
    repeat (5) @(negedge clk);
    total++; if (wr_data_q.size() != 0) $display("FAIL rw_no_partial_write: got %0d writes required 0", wr_data_q.size()); else pass_cnt++;
    total++; if (m_write !== 1'b0)      $display("FAIL rw_idle: got %b required 0", m_write); else pass_cnt++;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_junk_sync();
    test_zero_len();
    test_len_too_big();
    test_back_to_back();
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
